// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch (IF) and load/store (DM).
// Data accesses win over fetches. Define MEM_ARB_STATS_EN to add the stall_cycles counter output.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

    localparam logic [3:0] WCNT_LOAD = 4'(WAIT_CYCLES);

    state_t              state_q;
    grant_t              grant_q;
    logic [3:0]          wcnt_q;
    logic                we_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                if_ready_q;
    logic                dm_ready_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    // Memory-side outputs are loaded on the grant edge so the strobe lands in the ISSUE cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            grant_q     <= GNT_IF;
            wcnt_q      <= 4'd0;
            we_q        <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dm_req) begin
                        grant_q     <= GNT_DM;
                        we_q        <= dm_we;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                        state_q     <= ST_ISSUE;
                    end else if (if_req) begin
                        grant_q     <= GNT_IF;
                        we_q        <= 1'b0;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    wcnt_q      <= WCNT_LOAD;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    // <= 1 rather than == 1 keeps a corrupted zero count from hanging here
                    if (wcnt_q <= 4'd1) begin
                        wcnt_q <= 4'd0;
                        if (grant_q == GNT_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_ready_q <= 1'b1;
                        end
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign if_ready   = if_ready_q;
    assign dm_ready   = dm_ready_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    assign pipe_stall = ~RST & ((if_req & ~if_ready_q) | (dm_req & ~dm_ready_q));

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pipe_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (WAIT_CYCLES 2, 1, 15), each with a memory model,
// a cycle-level reference timeline, directed tables and randomized request traffic.
module tb_mem_port_arbiter;

    localparam int NI = 3;
    localparam int WC       [NI] = '{2, 1, 15};
    localparam int EXP_LAT  [NI] = '{4, 3, 17};
    localparam int RAND_CYC [NI] = '{1500, 800, 2500};

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } acc_vec_t;

    typedef struct {
        int dm_start;
        int exp_if_en;
        int exp_if_rdy;
        int exp_dm_en;
        int exp_dm_rdy;
    } pair_vec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t got=0x%0h exp=0x%0h", nm, inst, $time, act, exp);
        end
    endtask

    // Power-on memory contents; 0x40 holds the instruction used by the fetch scenario.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C22_0004;
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : env
        localparam int W = WC[g];

        logic        rst      = 1'b1;
        logic        if_req   = 1'b0;
        logic [31:0] if_addr  = '0;
        logic        dm_req   = 1'b0;
        logic        dm_we    = 1'b0;
        logic [31:0] dm_addr  = '0;
        logic [31:0] dm_wdata = '0;
        logic [31:0] mem_rdata = '0;
        logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
        logic        if_ready, dm_ready, mem_en, mem_we, pipe_stall;
`ifdef MEM_ARB_STATS_EN
        logic [31:0] stall_cycles;
`endif
        int cyc = 0;
        bit fin = 1'b0;

        mem_port_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .WAIT_CYCLES(W)
        ) u_dut (
            .CLK       (CLK),
            .RST       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_rdata  (if_rdata),
            .if_ready  (if_ready),
            .dm_req    (dm_req),
            .dm_we     (dm_we),
            .dm_addr   (dm_addr),
            .dm_wdata  (dm_wdata),
            .dm_rdata  (dm_rdata),
            .dm_ready  (dm_ready),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .pipe_stall(pipe_stall)
`ifdef MEM_ARB_STATS_EN
            ,
            .stall_cycles(stall_cycles)
`endif
        );

        // Memory: data is valid only in the single cycle W after the strobe, junk otherwise.
        logic [31:0] mem [logic [31:0]];
        int          due   = -1;
        logic [31:0] pdata = '0;
        always @(negedge CLK) begin
            mem_rdata = (cyc == due) ? pdata : $urandom;
            if (mem_en) begin
                due = cyc + W;
                if (mem_we) mem[mem_addr] = mem_wdata;
                else pdata = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
            end
        end

        // Reference timeline: a request seen free at edge e strobes in the cycle after e,
        // completes W+1 edges later and frees the port two edges after that.
        logic [31:0] ref_mem [logic [31:0]];
        bit          o_dm = 1'b0, o_we = 1'b0;
        logic [31:0] o_addr = '0, o_wdata = '0, o_data = '0;
        int          issue_c = -1, done_c = -1, free_c = 0;
        logic [31:0] e_if_rd = '0, e_dm_rd = '0, e_cnt = '0;
        bit          e_if_rdy = 1'b0, e_dm_rdy = 1'b0, e_en = 1'b0, stall_prev, e_stall;
        always @(posedge CLK) begin
            stall_prev = (if_req && !e_if_rdy) || (dm_req && !e_dm_rdy);
            cyc = cyc + 1;
            if (rst) begin
                e_cnt   = '0;
                e_if_rd = '0;
                e_dm_rd = '0;
                issue_c = -1;
                done_c  = -1;
                free_c  = cyc + 1;
            end else begin
                if (stall_prev && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
                if (cyc == done_c) begin
                    if (!o_dm) e_if_rd = o_data;
                    else if (!o_we) e_dm_rd = o_data;
                end
                if (cyc >= free_c && (if_req || dm_req)) begin
                    o_dm    = dm_req;
                    o_we    = dm_req && dm_we;
                    o_addr  = dm_req ? dm_addr : if_addr;
                    o_wdata = dm_req ? dm_wdata : '0;
                    if (o_we) ref_mem[o_addr] = o_wdata;
                    else o_data = ref_mem.exists(o_addr) ? ref_mem[o_addr] : init_word(o_addr);
                    issue_c = cyc;
                    done_c  = cyc + W + 1;
                    free_c  = cyc + W + 3;
                end
            end
            e_en     = (cyc == issue_c);
            e_if_rdy = (cyc == done_c) && !o_dm;
            e_dm_rdy = (cyc == done_c) && o_dm;
            #1;
            e_stall = !rst && ((if_req && !e_if_rdy) || (dm_req && !e_dm_rdy));
            chk("mem_en",     g, 64'(mem_en),    64'(e_en));
            chk("mem_we",     g, 64'(mem_we),    64'(e_en && o_we));
            chk("mem_addr",   g, 64'(mem_addr),  64'(e_en ? o_addr : 32'h0));
            chk("mem_wdata",  g, 64'(mem_wdata), 64'(e_en ? o_wdata : 32'h0));
            chk("if_ready",   g, 64'(if_ready),  64'(e_if_rdy));
            chk("dm_ready",   g, 64'(dm_ready),  64'(e_dm_rdy));
            chk("if_rdata",   g, 64'(if_rdata),  64'(e_if_rd));
            chk("dm_rdata",   g, 64'(dm_rdata),  64'(e_dm_rd));
            chk("pipe_stall", g, 64'(pipe_stall), 64'(e_stall));
`ifdef MEM_ARB_STATS_EN
            chk("stall_cycles", g, 64'(stall_cycles), 64'(e_cnt));
`endif
        end

        task automatic access(input bit dm, input bit we, input logic [31:0] a, input logic [31:0] wd,
                              output int lat, output logic [31:0] rd, output int en_rel,
                              output logic [31:0] en_addr, output logic en_we);
            int t;
            @(negedge CLK);
            if (dm) begin
                dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
            end else begin
                if_req = 1'b1; if_addr = a;
            end
            t = cyc + 1;
            lat = 0; rd = '0; en_rel = 0; en_addr = '0; en_we = 1'b0;
            for (int i = 0; i < 40 && lat == 0; i++) begin
                @(negedge CLK);
                if (mem_en && en_rel == 0) begin
                    en_rel = cyc - t + 1; en_addr = mem_addr; en_we = mem_we;
                end
                if (dm ? dm_ready : if_ready) begin
                    lat = cyc - t + 1;
                    rd  = dm ? dm_rdata : if_rdata;
                end
            end
            dm_req = 1'b0;
            if_req = 1'b0;
            @(negedge CLK);
        endtask

        task automatic pair(input int dm_start, output int ie, output int ir, output int de, output int dr);
            int t, rel;
            @(negedge CLK);
            if_req = 1'b1; if_addr = 32'h80;
            if (dm_start == 0) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
            end
            t = cyc + 1;
            ie = 0; ir = 0; de = 0; dr = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge CLK);
                rel = cyc - t + 1;
                if (mem_en && mem_addr == 32'h80  && ie == 0) ie = rel;
                if (mem_en && mem_addr == 32'h100 && de == 0) de = rel;
                if (if_ready && ir == 0) begin ir = rel; if_req = 1'b0; end
                if (dm_ready && dr == 0) begin dr = rel; dm_req = 1'b0; end
                if (rel == dm_start) begin
                    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
                end
            end
            if_req = 1'b0;
            dm_req = 1'b0;
        endtask

        initial begin
            acc_vec_t    tv [6];
            pair_vec_t   pv [2];
            int          lat, en_rel, ie, ir, de, dr;
            logic [31:0] rd, en_addr, s0;
            logic        en_we;
            bit          seen;

            tv[0] = '{dm: 1'b0, we: 1'b0, addr: 32'h40,  wdata: 32'h0,         exp_rd: 32'h8C22_0004};
            tv[1] = '{dm: 1'b1, we: 1'b1, addr: 32'h100, wdata: 32'hDEAD_BEEF, exp_rd: 32'h0};
            tv[2] = '{dm: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h0,         exp_rd: 32'hDEAD_BEEF};
            tv[3] = '{dm: 1'b1, we: 1'b1, addr: 32'h104, wdata: 32'h1234_5678, exp_rd: 32'hDEAD_BEEF};
            tv[4] = '{dm: 1'b0, we: 1'b0, addr: 32'h104, wdata: 32'h0,         exp_rd: 32'h1234_5678};
            tv[5] = '{dm: 1'b1, we: 1'b0, addr: 32'h40,  wdata: 32'h0,         exp_rd: 32'h8C22_0004};
            pv[0] = '{dm_start: 0, exp_if_en: 6, exp_if_rdy: 9, exp_dm_en: 1, exp_dm_rdy: 4};
            pv[1] = '{dm_start: 2, exp_if_en: 1, exp_if_rdy: 4, exp_dm_en: 6, exp_dm_rdy: 9};
            s0 = '0;

            repeat (3) @(negedge CLK);
            rst = 1'b0;

            // single fetch latency (and stall count) for every WAIT_CYCLES setting
`ifdef MEM_ARB_STATS_EN
            s0 = stall_cycles;
`endif
            access(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, en_rel, en_addr, en_we);
            chk("fetch_lat",   g, 64'(lat),    64'(EXP_LAT[g]));
            chk("fetch_rdata", g, 64'(rd),     64'h8C22_0004);
            chk("fetch_en",    g, 64'(en_rel), 64'd1);
`ifdef MEM_ARB_STATS_EN
            chk("stall_delta", g, 64'(stall_cycles - s0), 64'(EXP_LAT[g]));
`endif

            if (g == 0) begin
                for (int i = 0; i < 6; i++) begin
                    access(tv[i].dm, tv[i].we, tv[i].addr, tv[i].wdata, lat, rd, en_rel, en_addr, en_we);
                    chk($sformatf("tv%0d_lat", i),   g, 64'(lat),     64'd4);
                    chk($sformatf("tv%0d_rdata", i), g, 64'(rd),      64'(tv[i].exp_rd));
                    chk($sformatf("tv%0d_en", i),    g, 64'(en_rel),  64'd1);
                    chk($sformatf("tv%0d_addr", i),  g, 64'(en_addr), 64'(tv[i].addr));
                    chk($sformatf("tv%0d_we", i),    g, 64'(en_we),   64'(tv[i].we));
                end
                for (int i = 0; i < 2; i++) begin
                    pair(pv[i].dm_start, ie, ir, de, dr);
                    chk($sformatf("pair%0d_if_en", i),  g, 64'(ie), 64'(pv[i].exp_if_en));
                    chk($sformatf("pair%0d_if_rdy", i), g, 64'(ir), 64'(pv[i].exp_if_rdy));
                    chk($sformatf("pair%0d_dm_en", i),  g, 64'(de), 64'(pv[i].exp_dm_en));
                    chk($sformatf("pair%0d_dm_rdy", i), g, 64'(dr), 64'(pv[i].exp_dm_rdy));
                end

                // reset while a load sits in WAIT
                @(negedge CLK);
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
                @(negedge CLK);
                @(negedge CLK);
                rst = 1'b1;
                @(posedge CLK);
                #2;
                chk("rst_mem_en",   g, 64'(mem_en),     64'd0);
                chk("rst_mem_we",   g, 64'(mem_we),     64'd0);
                chk("rst_mem_addr", g, 64'(mem_addr),   64'd0);
                chk("rst_if_rdata", g, 64'(if_rdata),   64'd0);
                chk("rst_dm_rdata", g, 64'(dm_rdata),   64'd0);
                chk("rst_dm_ready", g, 64'(dm_ready),   64'd0);
                chk("rst_stall",    g, 64'(pipe_stall), 64'd0);
                @(negedge CLK);
                rst = 1'b0;
                dm_req = 1'b0;
                seen = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge CLK);
                    if (dm_ready) seen = 1'b1;
                end
                chk("rst_no_dm_ready", g, 64'(seen), 64'd0);
                access(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, en_rel, en_addr, en_we);
                chk("post_rst_lat",   g, 64'(lat), 64'd4);
                chk("post_rst_rdata", g, 64'(rd),  64'h8C22_0004);
            end

            for (int i = 0; i < RAND_CYC[g]; i++) begin
                @(negedge CLK);
                if (rst) rst = 1'b0;
                else if ($urandom_range(0, 299) == 0) rst = 1'b1;
                if (if_req) begin
                    if (if_ready) begin
                        if ($urandom_range(0, 3) == 0) if_addr = rnd_addr();
                        else if_req = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = rnd_addr();
                end
                if (dm_req) begin
                    if (dm_ready) begin
                        if ($urandom_range(0, 3) == 0) begin
                            dm_we = 1'($urandom_range(0, 1)); dm_addr = rnd_addr(); dm_wdata = $urandom;
                        end else begin
                            dm_req = 1'b0;
                        end
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = rnd_addr(); dm_wdata = $urandom;
                end
            end
            rst = 1'b0;
            if_req = 1'b0;
            dm_req = 1'b0;
            repeat (W + 6) @(negedge CLK);
            fin = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 20000 && !(env[0].fin && env[1].fin && env[2].fin); c++) @(posedge CLK);
        if (!(env[0].fin && env[1].fin && env[2].fin)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout got=not_done exp=all_done");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
